// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared constants, issue-action enum and pointer-width helper for the fetch stage
package fetch_queue_unit_pkg;

    localparam logic [31:0] FQ_NOP_IR        = 32'hFF00_0000;
    localparam int          FQ_DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        ISSUE_DEQ,
        ISSUE_BYPASS,
        ISSUE_HOLD,
        ISSUE_BUBBLE
    } issue_e;

    function automatic int fq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fetch_queue.sv
// rtl/fetch_queue_unit_fetch_queue.sv - negedge fetch FIFO; flush with a same-edge enqueue leaves exactly that entry
module fetch_queue
    import fetch_queue_unit_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = FQ_DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PTR_W = fq_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_addr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = enq;
        wr_addr  = wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_addr  = '0;
            wr_ptr_d = enq ? PTR_W'(1) : '0;
            count_d  = enq ? CNT_W'(1) : '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(negedge clk) begin
        if (wr_en) entries_q[wr_addr] <= din;
    end

    assign dout  = entries_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC generator, instruction memory and fetch queue; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  IR_WIDTH    = 32,
    parameter int                  QUEUE_DEPTH = FQ_DEFAULT_DEPTH,
    parameter int                  MEM_WORDS   = 1024,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [IR_WIDTH-1:0] NOP_IR      = IR_WIDTH'(FQ_NOP_IR),
    parameter string               INIT_FILE   = "test_branch.hex"
) (
    input  logic                             I_CLOCK,
    input  logic                             I_RESET,
    input  logic [PC_WIDTH-1:0]              I_BranchPC,
    input  logic                             I_BranchAddrSelect,
    input  logic                             I_BranchStallSignal,
    input  logic                             I_DepStallSignal,
    input  logic                             I_GPUStallSignal,
    output logic [PC_WIDTH-1:0]              O_PC,
    output logic [IR_WIDTH-1:0]              O_IR,
    output logic                             O_FE_Valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] O_QueueCount,
    output logic                             O_QueueFull
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int EW    = PC_WIDTH + IR_WIDTH;

    logic [IR_WIDTH-1:0] inst_mem [MEM_WORDS];

    logic [PC_WIDTH-1:0] fpc_q, fpc_d, addr_pc;
    logic [PC_WIDTH-1:0] o_pc_q, o_pc_d;
    logic [IR_WIDTH-1:0] o_ir_q, o_ir_d, fetch_ir;
    logic                o_valid_q, o_valid_d;
    logic                hold, q_enq, q_deq, q_full, bypass;
    logic [EW-1:0]       q_dout;
    logic [CNT_W-1:0]    q_count;
    issue_e              action;

    // A redirect fetches the branch target this edge instead of the sequential PC.
    assign addr_pc  = I_BranchAddrSelect ? I_BranchPC : fpc_q;
    assign fetch_ir = inst_mem[addr_pc[AW+1:2]];

    always_comb begin
        hold = I_DepStallSignal | I_GPUStallSignal;
        if (I_BranchAddrSelect)       action = ISSUE_BUBBLE;
        else if (hold)                action = ISSUE_HOLD;
        else if (I_BranchStallSignal) action = ISSUE_BUBBLE;
        else if (q_count != '0)       action = ISSUE_DEQ;
        else
`ifdef FETCH_QUEUE_BYPASS_EN
                                      action = ISSUE_BYPASS;
`else
                                      action = ISSUE_BUBBLE;
`endif

        q_deq  = (action == ISSUE_DEQ);
        bypass = (action == ISSUE_BYPASS);
        q_enq  = I_BranchAddrSelect | (!bypass & (!q_full | q_deq));
        fpc_d  = (q_enq | bypass) ? addr_pc + PC_WIDTH'(4) : fpc_q;

        o_pc_d    = o_pc_q;
        o_ir_d    = o_ir_q;
        o_valid_d = o_valid_q;
        case (action)
            ISSUE_DEQ: begin
                o_pc_d    = q_dout[EW-1:IR_WIDTH];
                o_ir_d    = q_dout[IR_WIDTH-1:0];
                o_valid_d = 1'b1;
            end
            ISSUE_BYPASS: begin
                o_pc_d    = addr_pc;
                o_ir_d    = fetch_ir;
                o_valid_d = 1'b1;
            end
            ISSUE_HOLD:   o_valid_d = o_valid_q;
            default:      o_valid_d = 1'b0;
        endcase
    end

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (I_CLOCK),
        .rst   (I_RESET),
        .enq   (q_enq),
        .deq   (q_deq),
        .flush (I_BranchAddrSelect),
        .din   ({addr_pc, fetch_ir}),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full)
    );

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            fpc_q     <= RESET_PC;
            o_pc_q    <= '0;
            o_ir_q    <= NOP_IR;
            o_valid_q <= 1'b0;
        end else begin
            fpc_q     <= fpc_d;
            o_pc_q    <= o_pc_d;
            o_ir_q    <= o_ir_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign O_PC         = o_pc_q;
    assign O_IR         = o_ir_q;
    assign O_FE_Valid   = o_valid_q;
    assign O_QueueCount = q_count;
    assign O_QueueFull  = q_full;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - vector table, corner sequences and randomized model check of fetch_queue_unit
module tb_fetch_queue_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'hFF00_0000;

    logic        I_CLOCK, I_RESET;
    logic [15:0] I_BranchPC;
    logic        I_BranchAddrSelect, I_BranchStallSignal, I_DepStallSignal, I_GPUStallSignal;
    logic [15:0] O_PC;
    logic [31:0] O_IR;
    logic        O_FE_Valid;
    logic [2:0]  O_QueueCount;
    logic        O_QueueFull;

    fetch_queue_unit #(
        .PC_WIDTH(16), .IR_WIDTH(32), .QUEUE_DEPTH(DEPTH), .MEM_WORDS(1024),
        .RESET_PC(16'h0000), .NOP_IR(NOP), .INIT_FILE("")
    ) dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_BranchPC(I_BranchPC),
        .I_BranchAddrSelect(I_BranchAddrSelect), .I_BranchStallSignal(I_BranchStallSignal),
        .I_DepStallSignal(I_DepStallSignal), .I_GPUStallSignal(I_GPUStallSignal),
        .O_PC(O_PC), .O_IR(O_IR), .O_FE_Valid(O_FE_Valid),
        .O_QueueCount(O_QueueCount), .O_QueueFull(O_QueueFull)
    );

    initial I_CLOCK = 1'b1;
    always #5 I_CLOCK = ~I_CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] model_mem [1024];
    logic [15:0] m_q [$];
    logic [15:0] m_fpc, m_pc;
    logic [31:0] m_ir;
    bit          m_valid;

    typedef struct {
        bit          dep;
        bit          bs;
        bit          redir;
        logic [15:0] bpc;
        logic [15:0] pc;
        bit          ir_nop;
        bit          valid;
        int          cnt;
        bit          full;
    } vec_t;
    vec_t tv [$];

    function automatic logic [31:0] mem_word(input logic [15:0] pc);
        return model_mem[pc[11:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc   = 16'h0000;
        m_pc    = 16'h0000;
        m_ir    = NOP;
        m_valid = 1'b0;
    endtask

    // Behavioural fetch stage: a bounded list of PCs, issued from the front.
    task automatic model_step();
        bit hold, go, bypassed;
        bypassed = 1'b0;
        if (I_BranchAddrSelect) begin
            m_q.delete();
            m_q.push_back(I_BranchPC);
            m_fpc   = I_BranchPC + 16'd4;
            m_valid = 1'b0;
        end else begin
            hold = I_DepStallSignal || I_GPUStallSignal;
            go   = !hold && !I_BranchStallSignal;
            if (go && m_q.size() > 0) begin
                m_pc    = m_q.pop_front();
                m_ir    = mem_word(m_pc);
                m_valid = 1'b1;
            end
`ifdef FETCH_QUEUE_BYPASS_EN
            else if (go) begin
                m_pc     = m_fpc;
                m_ir     = mem_word(m_fpc);
                m_valid  = 1'b1;
                m_fpc    = m_fpc + 16'd4;
                bypassed = 1'b1;
            end
`endif
            else if (!hold) m_valid = 1'b0;
            if (!bypassed && m_q.size() < DEPTH) begin
                m_q.push_back(m_fpc);
                m_fpc = m_fpc + 16'd4;
            end
        end
    endtask

    task automatic cycle();
        @(negedge I_CLOCK);
        model_step();
        @(posedge I_CLOCK);
        cyc++;
    endtask

    task automatic set_in(input bit dep, input bit gpu, input bit bs, input bit redir, input logic [15:0] bpc);
        I_DepStallSignal    = dep;
        I_GPUStallSignal    = gpu;
        I_BranchStallSignal = bs;
        I_BranchAddrSelect  = redir;
        I_BranchPC          = bpc;
    endtask

    task automatic check_model();
        check("pc", {16'h0, O_PC}, {16'h0, m_pc});
        check("ir", O_IR, m_ir);
        check("valid", {31'h0, O_FE_Valid}, {31'h0, m_valid});
        check("count", {29'h0, O_QueueCount}, m_q.size());
        check("full", {31'h0, O_QueueFull}, {31'h0, (m_q.size() == DEPTH)});
    endtask

    initial begin
        logic [31:0] w;
        I_RESET = 1'b1;
        set_in(0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 1024; i++) begin
            w = (i < 8) ? 32'h0000_00A0 + i : $urandom;
            model_mem[i]    = w;
            dut.inst_mem[i] = w;
        end
        model_reset();

        @(posedge I_CLOCK);
        @(posedge I_CLOCK);
        check("rst_pc", {16'h0, O_PC}, 32'h0);
        check("rst_ir", O_IR, NOP);
        check("rst_valid", {31'h0, O_FE_Valid}, 32'h0);
        check("rst_count", {29'h0, O_QueueCount}, 32'h0);
        check("rst_full", {31'h0, O_QueueFull}, 32'h0);
        I_RESET = 1'b0;

        // dep, bs, redir, bpc, exp pc, ir_nop, valid, count, full
        tv.push_back('{0, 0, 0, 16'h0, 16'h0000, 1, 0, 1, 0});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0000, 0, 1, 1, 0});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0004, 0, 1, 1, 0});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0008, 0, 1, 1, 0});
        tv.push_back('{1, 0, 0, 16'h0, 16'h0008, 0, 1, 2, 0});
        tv.push_back('{1, 0, 0, 16'h0, 16'h0008, 0, 1, 3, 0});
        tv.push_back('{1, 0, 0, 16'h0, 16'h0008, 0, 1, 4, 1});
        tv.push_back('{1, 0, 0, 16'h0, 16'h0008, 0, 1, 4, 1});
        tv.push_back('{1, 0, 0, 16'h0, 16'h0008, 0, 1, 4, 1});
        tv.push_back('{1, 0, 0, 16'h0, 16'h0008, 0, 1, 4, 1});
        tv.push_back('{0, 0, 0, 16'h0, 16'h000C, 0, 1, 4, 1});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0010, 0, 1, 4, 1});
        tv.push_back('{0, 1, 0, 16'h0, 16'h0010, 0, 0, 4, 1});
        tv.push_back('{0, 1, 0, 16'h0, 16'h0010, 0, 0, 4, 1});
        tv.push_back('{0, 1, 0, 16'h0, 16'h0010, 0, 0, 4, 1});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0014, 0, 1, 4, 1});
        tv.push_back('{1, 0, 1, 16'h0040, 16'h0014, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0040, 0, 1, 1, 0});
        tv.push_back('{0, 0, 0, 16'h0, 16'h0044, 0, 1, 1, 0});

        for (int i = 0; i < tv.size(); i++) begin
            set_in(tv[i].dep, 1'b0, tv[i].bs, tv[i].redir, tv[i].bpc);
            cycle();
            check($sformatf("tv%0d_pc", i), {16'h0, O_PC}, {16'h0, tv[i].pc});
            check($sformatf("tv%0d_ir", i), O_IR, tv[i].ir_nop ? NOP : mem_word(tv[i].pc));
            check($sformatf("tv%0d_valid", i), {31'h0, O_FE_Valid}, {31'h0, tv[i].valid});
            check($sformatf("tv%0d_count", i), {29'h0, O_QueueCount}, tv[i].cnt);
            check($sformatf("tv%0d_full", i), {31'h0, O_QueueFull}, {31'h0, tv[i].full});
        end

        // PC wrap: redirect to the last word, the next sequential PC is 0x0000.
        set_in(0, 0, 0, 1, 16'hFFFC);
        cycle();
        check("wrap_redir_valid", {31'h0, O_FE_Valid}, 32'h0);
        check("wrap_redir_count", {29'h0, O_QueueCount}, 32'd1);
        set_in(0, 0, 0, 0, 16'h0);
        cycle();
        check("wrap_pc0", {16'h0, O_PC}, 32'h0000_FFFC);
        check("wrap_ir0", O_IR, model_mem[1023]);
        check("wrap_valid0", {31'h0, O_FE_Valid}, 32'h1);
        cycle();
        check("wrap_pc1", {16'h0, O_PC}, 32'h0000_0000);
        check("wrap_ir1", O_IR, model_mem[0]);

        // Asynchronous reset between edges takes effect immediately.
        #2 I_RESET = 1'b1;
        #1;
        check("arst_pc", {16'h0, O_PC}, 32'h0);
        check("arst_ir", O_IR, NOP);
        check("arst_valid", {31'h0, O_FE_Valid}, 32'h0);
        check("arst_count", {29'h0, O_QueueCount}, 32'h0);
        check("arst_full", {31'h0, O_QueueFull}, 32'h0);
        @(posedge I_CLOCK);
        I_RESET = 1'b0;
        model_reset();

        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                   16'($urandom) & 16'hFFFC);
            cycle();
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
